// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - RAM read bus between the fetch unit and instruction/data memory
interface fetch_unit_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  modport master (
    output mem_addr,
    output mem_rd,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_addr,
    input  mem_rd,
    output mem_rdata,
    output mem_ack
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction/operand fetch stage owning PC, MAR, MBR and IR
module fetch_unit #(
  parameter int            AW       = 8,
  parameter int            DW       = 8,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter int            TIMEOUT  = 15
) (
  input  logic          fu_clk,
  input  logic          fu_rst_n,
  input  logic          fetch_req,
  input  logic          op_req,
  input  logic [AW-1:0] op_addr,
  input  logic          pc_load,
  input  logic [AW-1:0] pc_load_val,
  fetch_unit_if.master  mem,
  output logic [DW-1:0] ir_out,
  output logic          ir_valid,
  output logic [DW-1:0] mbr_out,
  output logic          mbr_valid,
  output logic [AW-1:0] pc_out,
  output logic          busy,
  output logic          fault
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] mar_q, mar_d;
  logic [DW-1:0] ir_q, ir_d;
  logic [DW-1:0] mbr_q, mbr_d;
  logic          is_fetch_q, is_fetch_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fault_q, fault_d;

  // State and datapath registers; reset abandons any read in flight.
  always_ff @(posedge fu_clk) begin
    if (!fu_rst_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      mar_q      <= '0;
      ir_q       <= '0;
      mbr_q      <= '0;
      is_fetch_q <= 1'b0;
      cnt_q      <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      mar_q      <= mar_d;
      ir_q       <= ir_d;
      mbr_q      <= mbr_d;
      is_fetch_q <= is_fetch_d;
      cnt_q      <= cnt_d;
      fault_q    <= fault_d;
    end
  end

  // Next-state: accept one request in IDLE (fetch over operand), wait for ack or timeout.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    mar_d      = mar_q;
    ir_d       = ir_q;
    mbr_d      = mbr_q;
    is_fetch_d = is_fetch_q;
    cnt_d      = cnt_q;
    fault_d    = fault_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (fetch_req) begin
          if (pc_load) begin
            mar_d = pc_load_val;
            pc_d  = pc_load_val;
          end else begin
            mar_d = pc_q;
          end
          is_fetch_d = 1'b1;
          state_d    = ST_REQ;
        end else if (op_req) begin
          mar_d      = op_addr;
          is_fetch_d = 1'b0;
          state_d    = ST_REQ;
        end else if (pc_load) begin
          pc_d = pc_load_val;
        end
      end
      ST_REQ: begin
        if (mem.mem_ack) begin
          mbr_d = mem.mem_rdata;
          if (is_fetch_q) begin
            ir_d = mem.mem_rdata;
            pc_d = pc_q + 1'b1;
          end
          state_d = ST_DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          // Give up on this read; nothing architectural changes except the fault flag.
          fault_d = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign mem.mem_addr = mar_q;
  assign mem.mem_rd   = (state_q == ST_REQ);
  assign ir_out       = ir_q;
  assign mbr_out      = mbr_q;
  assign pc_out       = pc_q;
  assign ir_valid     = (state_q == ST_DONE) && is_fetch_q;
  assign mbr_valid    = (state_q == ST_DONE) && !is_fetch_q;
  assign busy         = (state_q != ST_IDLE);
  assign fault        = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit against a transaction-level model
module tb_fetch_unit;
  localparam int TO = 15;

  logic       fu_clk;
  logic       fu_rst_n;
  logic       fetch_req;
  logic       op_req;
  logic [7:0] op_addr;
  logic       pc_load;
  logic [7:0] pc_load_val;
  logic [7:0] ir_out;
  logic       ir_valid;
  logic [7:0] mbr_out;
  logic       mbr_valid;
  logic [7:0] pc_out;
  logic       busy;
  logic       fault;

  fetch_unit_if #(.AW(8), .DW(8)) mif ();

  fetch_unit #(.AW(8), .DW(8), .RESET_PC(8'h00), .TIMEOUT(TO)) dut (
    .fu_clk      (fu_clk),
    .fu_rst_n    (fu_rst_n),
    .fetch_req   (fetch_req),
    .op_req      (op_req),
    .op_addr     (op_addr),
    .pc_load     (pc_load),
    .pc_load_val (pc_load_val),
    .mem         (mif.master),
    .ir_out      (ir_out),
    .ir_valid    (ir_valid),
    .mbr_out     (mbr_out),
    .mbr_valid   (mbr_valid),
    .pc_out      (pc_out),
    .busy        (busy),
    .fault       (fault)
  );

  initial begin
    fu_clk = 1'b0;
    forever #5 fu_clk = ~fu_clk;
  end

  int         ncmp = 0;
  int         nerr = 0;
  logic [7:0] ram [256];
  logic [7:0] m_pc, m_ir, m_mbr;
  logic       m_fault;

  task automatic step();
    @(posedge fu_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_arch(input string tag);
    chk({tag, "_pc"}, pc_out, m_pc);
    chk({tag, "_ir"}, ir_out, m_ir);
    chk({tag, "_mbr"}, mbr_out, m_mbr);
    chk({tag, "_fault"}, fault, m_fault);
  endtask

  task automatic model_reset();
    m_pc = 8'h00; m_ir = 8'h00; m_mbr = 8'h00; m_fault = 1'b0;
  endtask

  // One idle cycle: optional PC load and a stray ack that must be ignored.
  task automatic idle_cycle(input bit do_load, input logic [7:0] v, input bit ack_noise);
    pc_load = do_load; pc_load_val = v;
    mif.mem_ack = ack_noise; mif.mem_rdata = 8'($urandom);
    step();
    pc_load = 1'b0; mif.mem_ack = 1'b0;
    if (do_load) m_pc = v;
    chk("idle_busy", busy, 1'b0);
    chk("idle_rd", mif.mem_rd, 1'b0);
    chk("idle_irv", ir_valid, 1'b0);
    chk("idle_mbrv", mbr_valid, 1'b0);
    chk_arch("idle");
  endtask

  // A full read: waits >= TO means the memory never answers.
  task automatic run_txn(input bit is_fetch, input bit both, input logic [7:0] oaddr,
                         input bit do_load, input logic [7:0] lval, input int waits, input bit noise);
    logic [7:0] a;
    logic [7:0] d;
    bit         f;
    f = is_fetch || both;
    fetch_req = f; op_req = !is_fetch || both; op_addr = oaddr;
    pc_load = do_load; pc_load_val = lval;
    if (f) begin
      if (do_load) m_pc = lval;
      a = m_pc;
    end else begin
      a = oaddr;
    end
    step();
    fetch_req = 1'b0; op_req = 1'b0; pc_load = 1'b0;
    for (int w = 0; w < TO; w++) begin
      chk("req_rd", mif.mem_rd, 1'b1);
      chk("req_addr", mif.mem_addr, a);
      chk("req_busy", busy, 1'b1);
      chk("req_irv", ir_valid, 1'b0);
      if (noise) begin
        fetch_req = 1'($urandom); op_req = 1'($urandom); op_addr = 8'($urandom);
        pc_load = 1'($urandom); pc_load_val = 8'($urandom);
      end
      mif.mem_ack = (w == waits);
      mif.mem_rdata = (w == waits) ? ram[a] : 8'($urandom);
      step();
      mif.mem_ack = 1'b0;
      fetch_req = 1'b0; op_req = 1'b0; pc_load = 1'b0;
      if (w == waits) break;
    end
    if (waits < TO) begin
      d = ram[a];
      m_mbr = d;
      if (f) begin
        m_ir = d;
        m_pc = m_pc + 8'd1;
      end
      chk("done_rd", mif.mem_rd, 1'b0);
      chk("done_busy", busy, 1'b1);
      chk("done_irv", ir_valid, f);
      chk("done_mbrv", mbr_valid, !f);
      chk_arch("done");
      step();
      chk("post_busy", busy, 1'b0);
      chk("post_irv", ir_valid, 1'b0);
      chk("post_mbrv", mbr_valid, 1'b0);
    end else begin
      m_fault = 1'b1;
      chk("to_rd", mif.mem_rd, 1'b0);
      chk("to_busy", busy, 1'b0);
      chk("to_irv", ir_valid, 1'b0);
      chk("to_mbrv", mbr_valid, 1'b0);
      chk_arch("to");
    end
  endtask

  initial begin
    fu_rst_n = 1'b0; fetch_req = 1'b0; op_req = 1'b0; op_addr = 8'h00;
    pc_load = 1'b0; pc_load_val = 8'h00;
    mif.mem_ack = 1'b0; mif.mem_rdata = 8'h00;
    for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
    ram[8'h00] = 8'h47; ram[8'h3C] = 8'hA5; ram[8'hFF] = 8'h12;
    model_reset();

    step(); step();
    chk("rst_rd", mif.mem_rd, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_irv", ir_valid, 1'b0);
    chk("rst_mbrv", mbr_valid, 1'b0);
    chk("rst_mar", mif.mem_addr, 8'h00);
    chk_arch("rst");
    fu_rst_n = 1'b1;

    // Zero-wait fetch from address 00.
    run_txn(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 0, 1'b0);
    chk("t1_ir", ir_out, 8'h47);
    chk("t1_pc", pc_out, 8'h01);
    // Operand read with three wait cycles.
    run_txn(1'b0, 1'b0, 8'h3C, 1'b0, 8'h00, 3, 1'b0);
    chk("t2_mbr", mbr_out, 8'hA5);
    chk("t2_ir", ir_out, 8'h47);
    // PC load to FF, then fetch: PC wraps.
    idle_cycle(1'b1, 8'hFF, 1'b0);
    run_txn(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1, 1'b0);
    chk("t3_ir", ir_out, 8'h12);
    chk("t3_pc", pc_out, 8'h00);
    // Simultaneous fetch and operand request, then requests while busy.
    run_txn(1'b1, 1'b1, 8'h3C, 1'b0, 8'h00, 2, 1'b1);
    // No ack at all: timeout, then a normal fetch with fault still set.
    run_txn(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, TO, 1'b0);
    chk("t5_fault", fault, 1'b1);
    run_txn(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 0, 1'b0);
    chk("t5_fault_sticky", fault, 1'b1);

    // Reset asserted while a fetch is waiting; a late ack must be ignored.
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    chk("t6_rd_before", mif.mem_rd, 1'b1);
    step();
    fu_rst_n = 1'b0;
    step();
    model_reset();
    chk("t6_rd", mif.mem_rd, 1'b0);
    chk("t6_busy", busy, 1'b0);
    chk_arch("t6");
    fu_rst_n = 1'b1;
    mif.mem_ack = 1'b1; mif.mem_rdata = 8'h55;
    step();
    mif.mem_ack = 1'b0;
    chk("t6_late_irv", ir_valid, 1'b0);
    chk("t6_late_busy", busy, 1'b0);
    chk_arch("t6_late");

    // Randomised mix of fetches, operand reads, loads, stray acks and timeouts.
    for (int n = 0; n < 40; n++) begin
      int r;
      r = $urandom_range(0, 9);
      idle_cycle($urandom_range(0, 2) == 0, 8'($urandom), 1'($urandom));
      run_txn(1'($urandom), r == 0, 8'($urandom), $urandom_range(0, 3) == 0,
              8'($urandom), (r == 1) ? TO : $urandom_range(0, 4), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
